// File: rtl/riscv_pkg.sv
// riscv_pkg: shared data-memory request/response types, port ids and byte-enable helpers
package riscv_pkg;
   localparam int Xlen = 32;
   localparam int DmemPortCore = 0;
   localparam int DmemPortDbg = 1;
   localparam logic [3:0] DmemBeWord = 4'b1111;
   localparam logic [3:0] DmemBeHalfLo = 4'b0011;
   localparam logic [3:0] DmemBeHalfHi = 4'b1100;
   localparam logic [3:0] DmemBeByte = 4'b0001;
   typedef struct packed {
      logic            we;
      logic [3:0]      be;
      logic [Xlen-1:0] addr;
      logic [Xlen-1:0] wdata;
   } dmem_req_t;
   typedef struct packed {
      logic            err;
      logic [Xlen-1:0] rdata;
   } dmem_rsp_t;
   // Empty enables, unaligned words and odd halfwords are rejected; byte access is always aligned
   function automatic logic dmem_misaligned(input logic [3:0] be, input logic [1:0] a);
      return (be == 4'b0000) || (be == DmemBeWord && a != 2'b00) ||
             ((be == DmemBeHalfLo || be == DmemBeHalfHi) && a[0]);
   endfunction
endpackage

// File: rtl/dmem_prio_arbiter.sv
// dmem_prio_arbiter: two-input fixed-priority grant where input 1 is forced through after STARVE_LIMIT losses
module dmem_prio_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o
);
   localparam logic [3:0] Limit = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt, starve_nxt;
   logic       win1;
   // Grant and saturating starvation count; losing input 1 counts up, anything else clears
   always_comb begin
      win1 = valid_i[1] & (~valid_i[0] | (starve_cnt == Limit));
      grant_o = {win1, valid_i[0] & ~win1};
      starve_nxt = (valid_i[1] & ~win1) ? ((starve_cnt == Limit) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
   end
   // Starvation counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) starve_cnt <= 4'd0;
      else starve_cnt <= starve_nxt;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data SRAM between the load/store unit and the debug port
module dmem_arbiter
   import riscv_pkg::*;
#(
   parameter int XLEN = Xlen,
   parameter int MEM_SIZE = 2048,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [1:0]                  req_valid_i,
   output logic [1:0]                  req_ready_o,
   input  logic [1:0]                  req_we_i,
   input  logic [1:0][3:0]             req_be_i,
   input  logic [1:0][XLEN-1:0]        req_addr_i,
   input  logic [1:0][XLEN-1:0]        req_wdata_i,
   output logic [1:0]                  rsp_valid_o,
   output logic                        rsp_err_o,
   output logic [XLEN-1:0]             rsp_rdata_o,
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [3:0]                  mem_be_o,
   output logic [$clog2(MEM_SIZE)-1:0] mem_addr_o,
   output logic [XLEN-1:0]             mem_wdata_o,
   input  logic [XLEN-1:0]             mem_rdata_i
);
   localparam int Aw = $clog2(MEM_SIZE);
   logic [1:0] gnt_raw, gnt, rsp_vld_q;
   logic       sel_port, any, err, err_q, we_q;
   dmem_req_t  sel;
   dmem_rsp_t  rsp;
   dmem_prio_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (req_valid_i),
      .grant_o (gnt_raw)
   );
   // Winner mux, error check and SRAM issue; everything is held quiet while reset is asserted
   always_comb begin
      gnt = gnt_raw & {2{~rst_i}};
      sel_port = gnt[DmemPortDbg];
      any = |gnt;
      sel = '{we: req_we_i[sel_port], be: req_be_i[sel_port], addr: req_addr_i[sel_port], wdata: req_wdata_i[sel_port]};
      err = any & (dmem_misaligned(sel.be, sel.addr[1:0]) || (sel.addr[XLEN-1:2] >= (XLEN-2)'(MEM_SIZE)));
      req_ready_o = gnt;
      mem_req_o = any & ~err;
      mem_we_o = mem_req_o & sel.we;
      mem_be_o = mem_req_o ? sel.be : 4'b0000;
      mem_addr_o = mem_req_o ? sel.addr[Aw+1:2] : '0;
      mem_wdata_o = mem_req_o ? sel.wdata : '0;
      rsp.err = err_q;
      rsp.rdata = (|rsp_vld_q & ~err_q & ~we_q) ? mem_rdata_i : '0;
      rsp_valid_o = rsp_vld_q;
      rsp_err_o = rsp.err;
      rsp_rdata_o = rsp.rdata;
   end
   // Response bookkeeping: owner, error and direction of the access issued this cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_vld_q <= 2'b00;
         err_q <= 1'b0;
         we_q <= 1'b0;
      end else begin
         rsp_vld_q <= gnt;
         err_q <= err;
         we_q <= any & sel.we;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant, starvation, error and reset behaviour with an SRAM model
module tb_dmem_arbiter;
   logic             clk_i = 1'b0, rst_i = 1'b1;
   logic [1:0]       req_valid_i = 2'b00, req_ready_o, req_we_i = 2'b00, rsp_valid_o;
   logic [1:0][3:0]  req_be_i = '0;
   logic [1:0][31:0] req_addr_i = '0, req_wdata_i = '0;
   logic             rsp_err_o, mem_req_o, mem_we_o;
   logic [31:0]      rsp_rdata_o, mem_wdata_o, mem_rdata_i = '0;
   logic [3:0]       mem_be_o;
   logic [10:0]      mem_addr_o;
   logic [31:0]      sram [2048];
   int               errs = 0, checks = 0;

   dmem_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (mem_req_o && mem_we_o) begin
         for (int b = 0; b < 4; b++) if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else if (mem_req_o) mem_rdata_i <= sram[mem_addr_o];
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_port(input int p, input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
      req_valid_i[p] = 1'b1;
      req_we_i[p] = we;
      req_be_i[p] = be;
      req_addr_i[p] = addr;
      req_wdata_i[p] = wd;
   endtask

   task automatic test_reset();
      set_port(0, 1'b0, 4'hF, 32'h0, 32'h0);
      set_port(1, 1'b0, 4'hF, 32'h4, 32'h0);
      #3;
      checks++; if (req_ready_o !== 2'b00) begin errs++; $display("FAIL reset_ready got %b want 00", req_ready_o); end
      checks++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL reset_mem_req got %b want 0", mem_req_o); end
      checks++; if (rsp_valid_o !== 2'b00 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin errs++; $display("FAIL reset_rsp got %b/%h/%b want 00/0/0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
      req_valid_i = 2'b00;
      #4 rst_i = 1'b0;
   endtask

   task automatic test_read();
      sram[4] = 32'hDEADBEEF;
      tick();
      set_port(0, 1'b0, 4'hF, 32'h10, 32'h0);
      #1;
      checks++; if (req_ready_o !== 2'b01) begin errs++; $display("FAIL read_ready got %b want 01", req_ready_o); end
      checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 11'd4) begin errs++; $display("FAIL read_issue got req=%b we=%b addr=%0d want 1/0/4", mem_req_o, mem_we_o, mem_addr_o); end
      tick();
      req_valid_i = 2'b00;
      #1;
      checks++; if (rsp_valid_o !== 2'b01 || rsp_rdata_o !== 32'hDEADBEEF || rsp_err_o !== 1'b0) begin errs++; $display("FAIL read_rsp got %b/%h/%b want 01/deadbeef/0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
      tick();
      #1;
      checks++; if (rsp_valid_o !== 2'b00) begin errs++; $display("FAIL read_rsp_once got %b want 00", rsp_valid_o); end
   endtask

   task automatic test_starve();
      logic [1:0] exp_g [10];
      sram[8] = 32'hA0A0A0A0;
      sram[9] = 32'hB1B1B1B1;
      for (int i = 0; i < 10; i++) exp_g[i] = (i % 5 == 4) ? 2'b10 : 2'b01;
      for (int i = 0; i < 10; i++) begin
         tick();
         set_port(0, 1'b0, 4'hF, 32'h20, 32'h0);
         set_port(1, 1'b0, 4'hF, 32'h24, 32'h0);
         #1;
         checks++; if (req_ready_o !== exp_g[i]) begin errs++; $display("FAIL starve_grant[%0d] got %b want %b", i, req_ready_o, exp_g[i]); end
         if (i > 0) begin
            checks++;
            if (rsp_valid_o !== exp_g[i-1] || rsp_rdata_o !== (exp_g[i-1][1] ? 32'hB1B1B1B1 : 32'hA0A0A0A0)) begin
               errs++; $display("FAIL starve_rsp[%0d] got %b/%h want %b", i, rsp_valid_o, rsp_rdata_o, exp_g[i-1]);
            end
         end
      end
      tick();
      req_valid_i = 2'b00;
      #1;
      checks++; if (rsp_valid_o !== 2'b10 || rsp_rdata_o !== 32'hB1B1B1B1) begin errs++; $display("FAIL starve_last_rsp got %b/%h want 10/b1b1b1b1", rsp_valid_o, rsp_rdata_o); end
   endtask

   task automatic test_back_to_back();
      tick();
      set_port(1, 1'b1, 4'hF, 32'h1FFC, 32'h12345678);
      #1;
      checks++; if (req_ready_o !== 2'b10 || mem_we_o !== 1'b1 || mem_addr_o !== 11'h7FF || mem_wdata_o !== 32'h12345678) begin
         errs++; $display("FAIL b2b_write got rdy=%b we=%b addr=%h wd=%h want 10/1/7ff/12345678", req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      tick();
      req_valid_i = 2'b00;
      set_port(0, 1'b0, 4'hF, 32'h1FFC, 32'h0);
      #1;
      checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin errs++; $display("FAIL b2b_write_ack got %b/%b/%h want 10/0/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      checks++; if (req_ready_o !== 2'b01 || mem_req_o !== 1'b1) begin errs++; $display("FAIL b2b_read_issue got rdy=%b req=%b want 01/1", req_ready_o, mem_req_o); end
      tick();
      req_valid_i = 2'b00;
      #1;
      checks++; if (rsp_valid_o !== 2'b01 || rsp_rdata_o !== 32'h12345678) begin errs++; $display("FAIL b2b_read_rsp got %b/%h want 01/12345678", rsp_valid_o, rsp_rdata_o); end
   endtask

   task automatic test_errors();
      logic [31:0] va [5] = '{32'h2002, 32'h2000, 32'h11, 32'h10, 32'h12};
      logic [3:0]  vb [5] = '{4'hF, 4'hF, 4'h3, 4'h0, 4'hC};
      logic        ve [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         tick();
         set_port(0, 1'b0, vb[i], va[i], 32'h0);
         #1;
         checks++; if (req_ready_o !== 2'b01 || mem_req_o !== !ve[i]) begin errs++; $display("FAIL err_issue[%0d] got rdy=%b req=%b want 01/%b", i, req_ready_o, mem_req_o, !ve[i]); end
         tick();
         req_valid_i = 2'b00;
         #1;
         checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== ve[i] || rsp_rdata_o !== (ve[i] ? 32'h0 : 32'hDEADBEEF)) begin
            errs++; $display("FAIL err_rsp[%0d] got %b/%b/%h want 01/%b", i, rsp_valid_o, rsp_err_o, rsp_rdata_o, ve[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         set_port(0, 1'b0, 4'hF, 32'h20, 32'h0);
         set_port(1, 1'b0, 4'hF, 32'h24, 32'h0);
      end
      #2 rst_i = 1'b1;
      #1;
      checks++; if (req_ready_o !== 2'b00 || mem_req_o !== 1'b0) begin errs++; $display("FAIL arst_issue got rdy=%b req=%b want 00/0", req_ready_o, mem_req_o); end
      checks++; if (rsp_valid_o !== 2'b00 || rsp_rdata_o !== 32'h0) begin errs++; $display("FAIL arst_rsp got %b/%h want 00/0", rsp_valid_o, rsp_rdata_o); end
      tick();
      checks++; if (rsp_valid_o !== 2'b00) begin errs++; $display("FAIL arst_dropped got %b want 00", rsp_valid_o); end
      #1 rst_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         #1;
         checks++; if (req_ready_o !== ((i == 4) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL arst_starve[%0d] got %b want %b", i, req_ready_o, (i == 4) ? 2'b10 : 2'b01); end
      end
      tick();
      req_valid_i = 2'b00;
   endtask

   initial begin
      test_reset();
      test_read();
      test_starve();
      test_back_to_back();
      test_errors();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
